add_to_acap: RTL and testbench
==============================

ADD_TO_ACAP -- requirements
Module: add_to_acap

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- RING_SIZE, 1024, ring dimension N.
- DATA_W, 32, coefficient width.
- Q, 32'd134215681, coefficient modulus; all stored operands < Q.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on rising edge.
- resetn, in, 1, reset; asynchronous, active-low.
- data_in, in, 32, BRAM read data; valid one cycle after its address was presented.
- write_enable_bram, out, 4, byte write enables; 4'b1111 = write word, 4'b0000 = read.
- port_enable, out, 1, BRAM port enable; high whenever the block drives an access.
- write_addr_interfacebram, out, 32, BRAM word address for read or write.
- data_out, out, 32, BRAM write data.
REQ-003 Memory map (word addresses):
- 0x0000-0x07FF: accumulator A[0..2N-1].
- 0x0800-0x0FFF: addend B[0..2N-1].
- 0x1004: start mailbox.
- 0x1789: done mailbox.
- 0x1800-0x1FFF: result R[0..2N-1].

Function
REQ-004 FSM states: POLL, CHECK, CLEAR, RD_A, RD_B, SUM, WR, DONE, in that cycle order; each state lasts one cycle.
REQ-005 POLL: read address 0x1004, go to CHECK.
REQ-006 CHECK: if data_in == 32'hDEADBEEF go to CLEAR, else go back to POLL; the address stays 0x1004.
REQ-007 CLEAR: write 32'h00000000 to 0x1004, reset index i to 0, go to RD_A.
REQ-008 RD_A: read address i.
REQ-009 RD_B: read address 0x0800+i; capture data_in (= A[i]).
REQ-010 SUM: compute s = A[i] + data_in in 33 bits; R = s - Q if s >= Q, else s; register R.
REQ-011 WR: write R to 0x1800+i. If i == 2N-1 go to DONE; else i <= i+1 and go to RD_A.
REQ-012 DONE: write 32'hD01ECAFE to 0x1789, go to POLL; the block is then re-armable.
REQ-013 write_enable_bram is 4'b1111 only in CLEAR, WR and DONE; it is 4'b0000 otherwise.
REQ-014 port_enable is 1 in every state after reset.
REQ-015 data_out is 0 except in CLEAR, WR and DONE.
REQ-016 Outputs are decoded combinationally from state, i and the R register; there are no glitches on write_enable_bram outside the write states.
REQ-017 Steady-state throughput is 4 cycles per coefficient: 2N*4 + 4 cycles from start detection to the done write (8196 cycles at N=1024).
REQ-018 External collision: the block does not arbitrate. A foreign write to 0x1004 during polling is picked up on a later poll. A corrupted CHECK value returns to POLL.
REQ-019 A start word written while the block is busy is ignored until the next POLL. It is then executed, and CLEAR consumes it.

Reset
REQ-020 While resetn = 0, the block is asynchronously held as follows:
- state = POLL, i = 0, R = 0.
- write_enable_bram = 0, port_enable = 0, address = 0, data_out = 0.
REQ-021 Reset mid-operation aborts the run: no further result writes and no done write. Results already written remain in memory.
REQ-022 The first access after resetn rises is the POLL read of 0x1004.

Structure
REQ-023 The following go in a shared package: memory-map constants (A_BASE, B_BASE, START_ADDR, DONE_ADDR, RES_BASE), the magic words (START_MAGIC, DONE_MAGIC) and the FSM state enum.
REQ-024 One sub-module, mod_add (combinational (a+b) mod Q, parameterised on DATA_W and Q); the top contains only the FSM, the counter and the output decode.

Verification
REQ-025 The bench models an 8N-word BRAM with 1-cycle registered read, sharing the address with the block.
REQ-026 Scenario (no start): mailbox 0x1004 = 0 for 2000 cycles -> the block never writes (write_enable_bram stays 0) and 0x1789 is unchanged.
REQ-027 Scenario (basic run): A[i] = i, B[i] = 2i, then 0xDEADBEEF is written to 0x1004 -> R[i] = 3i for all 2048 words. 0x1004 reads 0, and 0x1789 reads 0xD01ECAFE exactly 8196 cycles after detection.
REQ-028 Scenario (modular boundaries):
- A = Q-1, B = 1 -> 0.
- A = Q-1, B = Q-1 -> Q-2.
- A = 0, B = 0 -> 0.
REQ-029 Scenario (near-miss start): 0xDEADBE3F written to 0x1004 -> no run starts.
REQ-030 Scenario (reset mid-run): resetn pulsed low at i = 500 -> outputs are 0 immediately, 0x1789 is not written, and R[500..2047] are unchanged.
REQ-031 Scenario (re-arm): after completion, 0x1789 is cleared, new data is loaded and 0xDEADBEEF is written again -> the second results are correct and the done word is rewritten.

Source files
------------

// File: rtl/add_to_acap_pkg.sv
// Shared memory map, mailbox magic words and FSM state encoding for add_to_acap.
package add_to_acap_pkg;

  localparam logic [31:0] A_BASE     = 32'h0000_0000;
  localparam logic [31:0] B_BASE     = 32'h0000_0800;
  localparam logic [31:0] START_ADDR = 32'h0000_1004;
  localparam logic [31:0] DONE_ADDR  = 32'h0000_1789;
  localparam logic [31:0] RES_BASE   = 32'h0000_1800;

  localparam logic [31:0] START_MAGIC = 32'hDEAD_BEEF;
  localparam logic [31:0] DONE_MAGIC  = 32'hD01E_CAFE;

  typedef enum logic [2:0] {
    POLL  = 3'd0,
    CHECK = 3'd1,
    CLEAR = 3'd2,
    RD_A  = 3'd3,
    RD_B  = 3'd4,
    SUM   = 3'd5,
    WR    = 3'd6,
    DONE  = 3'd7
  } state_e;

endpackage

// File: rtl/add_to_acap_mod_add.sv
// Combinational modular add: (a + b) mod Q, both operands assumed already < Q.
module mod_add #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] Q      = 32'd134215681
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W:0] s;
  logic [DATA_W:0] d;

  // One extra bit keeps the carry so s >= Q is exact even when a+b overflows DATA_W.
  always_comb begin
    s   = {1'b0, a} + {1'b0, b};
    d   = s - {1'b0, Q};
    sum = (s >= {1'b0, Q}) ? d[DATA_W-1:0] : s[DATA_W-1:0];
  end

endmodule

// File: rtl/add_to_acap.sv
// Mailbox-triggered BRAM engine: R[i] = (A[i] + B[i]) mod Q over 2N words, then posts a done word.
module add_to_acap
  import add_to_acap_pkg::*;
#(
  parameter int                RING_SIZE = 1024,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] Q         = 32'd134215681
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] data_in,
  output logic [3:0]  write_enable_bram,
  output logic        port_enable,
  output logic [31:0] write_addr_interfacebram,
  output logic [31:0] data_out
);

  localparam int            IW   = $clog2(2 * RING_SIZE);
  localparam logic [IW-1:0] LAST = IW'(2 * RING_SIZE - 1);

  state_e            state;
  logic              active;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] sum;

  mod_add #(.DATA_W(DATA_W), .Q(Q)) u_mod_add (
    .a   (a_q),
    .b   (data_in[DATA_W-1:0]),
    .sum (sum)
  );

  // 'active' holds the port quiet for the cycle after reset so the first access is the POLL read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= POLL;
      active <= 1'b0;
      idx    <= '0;
      a_q    <= '0;
      r_q    <= '0;
    end else if (!active) begin
      active <= 1'b1;
    end else begin
      case (state)
        POLL:  state <= CHECK;
        CHECK: state <= (data_in == START_MAGIC) ? CLEAR : POLL;
        CLEAR: begin
          idx   <= '0;
          state <= RD_A;
        end
        RD_A:  state <= RD_B;
        RD_B: begin
          a_q   <= data_in[DATA_W-1:0];
          state <= SUM;
        end
        SUM: begin
          r_q   <= sum;
          state <= WR;
        end
        WR: begin
          if (idx == LAST) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= RD_A;
          end
        end
        DONE:    state <= POLL;
        default: state <= POLL;
      endcase
    end
  end

  always_comb begin
    write_enable_bram        = 4'b0000;
    port_enable              = 1'b0;
    write_addr_interfacebram = 32'h0;
    data_out                 = 32'h0;
    if (active) begin
      port_enable = 1'b1;
      case (state)
        POLL, CHECK: write_addr_interfacebram = START_ADDR;
        CLEAR: begin
          write_enable_bram        = 4'b1111;
          write_addr_interfacebram = START_ADDR;
        end
        RD_A:      write_addr_interfacebram = A_BASE + 32'(idx);
        RD_B, SUM: write_addr_interfacebram = B_BASE + 32'(idx);
        WR: begin
          write_enable_bram        = 4'b1111;
          write_addr_interfacebram = RES_BASE + 32'(idx);
          data_out                 = 32'(r_q);
        end
        DONE: begin
          write_enable_bram        = 4'b1111;
          write_addr_interfacebram = DONE_ADDR;
          data_out                 = DONE_MAGIC;
        end
        default: write_addr_interfacebram = START_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_add_to_acap.sv
// Directed bench for add_to_acap against an 8N-word BRAM model with 1-cycle registered read.
module tb_add_to_acap;

  localparam int          NW     = 2048;
  localparam logic [31:0] QM     = 32'd134215681;
  localparam int          A_B    = 'h0000;
  localparam int          B_B    = 'h0800;
  localparam int          START  = 'h1004;
  localparam int          DONEA  = 'h1789;
  localparam int          RES_B  = 'h1800;
  localparam logic [31:0] MAGIC  = 32'hDEADBEEF;
  localparam logic [31:0] DMAGIC = 32'hD01ECAFE;
  localparam logic [31:0] SENT_A = 32'hA5A5A5A5;
  localparam logic [31:0] SENT_B = 32'h5A5A5A5A;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] data_in;
  logic [3:0]  we;
  logic        pe;
  logic [31:0] addr;
  logic [31:0] dout;

  logic [31:0] mem [0:8191];
  logic        bw;
  logic [12:0] ba;
  logic [31:0] bd;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  add_to_acap dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .data_in                  (data_in),
    .write_enable_bram        (we),
    .port_enable              (pe),
    .write_addr_interfacebram (addr),
    .data_out                 (dout)
  );

  // BRAM model; the bench's own write port is applied after the DUT's so it wins a collision.
  always @(posedge clk) begin
    if (pe) begin
      if (we == 4'hF) mem[addr[12:0]] <= dout;
      data_in <= mem[addr[12:0]];
    end
    if (bw) mem[ba] <= bd;
  end

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bw = 1'b1;
    ba = 13'(a);
    bd = d;
    @(posedge clk);
    #1 bw = 1'b0;
  endtask

  task automatic run_wait(output int clr_c, output int done_c);
    int cyc;
    cyc    = 0;
    clr_c  = -1;
    done_c = -1;
    while (cyc < 20000 && done_c < 0) begin
      @(negedge clk);
      cyc++;
      if (we == 4'hF && addr == 32'(START)) clr_c = cyc;
      if (we == 4'hF && addr == 32'(DONEA)) done_c = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string nm, input int clr_c, input int done_c);
    checks++;
    if (clr_c < 0 || done_c < 0)
      $display("FAIL %s_complete: clear=%0d done=%0d, want both seen", nm, clr_c, done_c);
    else passed++;
    // POLL and CHECK precede the CLEAR cycle, so the detection-to-done span is clear..done + 3.
    checks++;
    if (done_c - clr_c + 3 !== 8196)
      $display("FAIL %s_latency: got %0d cycles, want 8196", nm, done_c - clr_c + 3);
    else passed++;
    checks++;
    if (mem[START] !== 32'h0)
      $display("FAIL %s_mailbox_cleared: got %h, want 00000000", nm, mem[START]);
    else passed++;
    checks++;
    if (mem[DONEA] !== DMAGIC)
      $display("FAIL %s_done_word: got %h, want %h", nm, mem[DONEA], DMAGIC);
    else passed++;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bw     = 1'b0;
    ba     = '0;
    bd     = '0;
    repeat (3) @(negedge clk);
    checks++; if (we !== 4'h0)  $display("FAIL reset_we: got %h, want 0", we);     else passed++;
    checks++; if (pe !== 1'b0)  $display("FAIL reset_pe: got %b, want 0", pe);     else passed++;
    checks++; if (addr !== 32'h0) $display("FAIL reset_addr: got %h, want 0", addr); else passed++;
    checks++; if (dout !== 32'h0) $display("FAIL reset_dout: got %h, want 0", dout); else passed++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pe !== 1'b1 || we !== 4'h0 || addr !== 32'(START))
      $display("FAIL first_access: pe=%b we=%h addr=%h, want 1 0 00001004", pe, we, addr);
    else passed++;
  endtask

  task automatic test_no_start;
    int bad;
    logic [31:0] done_before;
    wr(START, 32'h0);
    wr(DONEA, 32'h0);
    done_before = mem[DONEA];
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (we !== 4'h0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL nostart_we: got %0d write cycles, want 0", bad); else passed++;
    checks++;
    if (mem[DONEA] !== done_before)
      $display("FAIL nostart_done: got %h, want %h", mem[DONEA], done_before);
    else passed++;
  endtask

  task automatic test_basic;
    int clr_c, done_c, errs, first;
    for (int k = 0; k < NW; k++) begin
      wr(A_B + k, 32'(k));
      wr(B_B + k, 32'(2 * k));
      wr(RES_B + k, SENT_A);
    end
    wr(START, MAGIC);
    run_wait(clr_c, done_c);
    check_run("basic", clr_c, done_c);
    errs  = 0;
    first = 0;
    for (int k = 0; k < NW; k++)
      if (mem[RES_B + k] !== 32'(3 * k)) begin
        if (errs == 0) first = k;
        errs++;
      end
    checks++;
    if (errs !== 0)
      $display("FAIL basic_results: %0d wrong, R[%0d]=%h want %h", errs, first,
               mem[RES_B + first], 32'(3 * first));
    else passed++;
  endtask

  task automatic test_modular;
    int clr_c, done_c;
    wr(A_B + 0, QM - 1); wr(B_B + 0, 32'd1);
    wr(A_B + 1, QM - 1); wr(B_B + 1, QM - 1);
    wr(A_B + 2, 32'd0);  wr(B_B + 2, 32'd0);
    for (int k = 0; k < 4; k++) wr(RES_B + k, SENT_A);
    wr(DONEA, 32'h0);
    wr(START, MAGIC);
    run_wait(clr_c, done_c);
    check_run("modular", clr_c, done_c);
    checks++; if (mem[RES_B + 0] !== 32'd0)  $display("FAIL mod_wrap_to_zero: got %h, want 0", mem[RES_B + 0]); else passed++;
    checks++; if (mem[RES_B + 1] !== QM - 2) $display("FAIL mod_max_sum: got %h, want %h", mem[RES_B + 1], QM - 2); else passed++;
    checks++; if (mem[RES_B + 2] !== 32'd0)  $display("FAIL mod_zero: got %h, want 0", mem[RES_B + 2]); else passed++;
    checks++; if (mem[RES_B + 3] !== 32'd9)  $display("FAIL mod_plain: got %h, want 9", mem[RES_B + 3]); else passed++;
  endtask

  task automatic test_near_miss;
    int bad;
    wr(START, 32'hDEADBE3F);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (we !== 4'h0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL nearmiss_we: got %0d write cycles, want 0", bad); else passed++;
    checks++;
    if (mem[START] !== 32'hDEADBE3F)
      $display("FAIL nearmiss_mailbox: got %h, want deadbe3f", mem[START]);
    else passed++;
    wr(START, 32'h0);
  endtask

  task automatic test_rearm;
    int clr_c, done_c, errs, first;
    wr(DONEA, 32'h0);
    for (int k = 0; k < NW; k++) begin
      wr(A_B + k, 32'(7 * k + 1));
      wr(B_B + k, QM - 1 - 32'(k));
    end
    wr(START, MAGIC);
    run_wait(clr_c, done_c);
    check_run("rearm", clr_c, done_c);
    errs  = 0;
    first = 0;
    for (int k = 0; k < NW; k++)
      if (mem[RES_B + k] !== 32'(6 * k)) begin
        if (errs == 0) first = k;
        errs++;
      end
    checks++;
    if (errs !== 0)
      $display("FAIL rearm_results: %0d wrong, R[%0d]=%h want %h", errs, first,
               mem[RES_B + first], 32'(6 * first));
    else passed++;
  endtask

  task automatic test_reset_mid;
    int cyc, errs;
    bit hit;
    for (int k = 0; k < NW; k++) wr(RES_B + k, SENT_B);
    wr(DONEA, 32'h0);
    wr(START, MAGIC);
    cyc = 0;
    hit = 1'b0;
    while (cyc < 10000 && !hit) begin
      @(negedge clk);
      cyc++;
      if (pe === 1'b1 && we === 4'h0 && addr === 32'(A_B + 500)) hit = 1'b1;
    end
    checks++;
    if (!hit) $display("FAIL midreset_reach_500: got timeout after %0d cycles, want RD_A of 500", cyc);
    else passed++;
    resetn = 1'b0;
    #1;
    checks++;
    if (we !== 4'h0 || pe !== 1'b0 || addr !== 32'h0 || dout !== 32'h0)
      $display("FAIL midreset_outputs: we=%h pe=%b addr=%h dout=%h, want all 0", we, pe, addr, dout);
    else passed++;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (300) @(negedge clk);
    errs = 0;
    for (int k = 500; k < NW; k++) if (mem[RES_B + k] !== SENT_B) errs++;
    checks++;
    if (errs !== 0) $display("FAIL midreset_tail: got %0d overwritten words, want 0", errs); else passed++;
    checks++;
    if (mem[RES_B + 499] !== 32'd2994)
      $display("FAIL midreset_head: got %h, want %h", mem[RES_B + 499], 32'd2994);
    else passed++;
    checks++;
    if (mem[DONEA] !== 32'h0) $display("FAIL midreset_done: got %h, want 0", mem[DONEA]); else passed++;
  endtask

  initial begin
    test_reset;
    test_no_start;
    test_basic;
    test_modular;
    test_near_miss;
    test_rearm;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
